muldiv_unit: RTL

- Iterative multiply/divide unit that owns the HI/LO register pair for the MiniSys-1A core.
- Executes the mult, multu, div, divu, mfhi, mflo, mthi and mtlo operations flagged by the instruction decoder.
- Sequences a 32-step shift-add multiply or restoring divide over rs/rt operands.
- Raises a stall request to the pipeline whenever a HI/LO access or new start collides with an operation in progress.

---
 rtl/muldiv_unit.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Iterative 32-step shift-add multiply / restoring divide unit owning the HI/LO pair.
// Signed operations run on magnitudes; sign correction is applied in the final FIX cycle.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op_mult,
  input  logic             op_multu,
  input  logic             op_div,
  input  logic             op_divu,
  input  logic             op_mfhi,
  input  logic             op_mflo,
  input  logic             op_mthi,
  input  logic             op_mtlo,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic             stall
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t               r_state, w_next;
  logic [CNT_W-1:0]     r_cnt;
  logic [2*WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]     r_b, r_rs, r_hi, r_lo;
  logic                 r_is_div, r_neg_q, r_neg_r, r_dbz, r_done, r_dz;

  logic                 w_go, w_signed, w_is_div, w_rs_neg, w_rt_neg;
  logic [WIDTH-1:0]     w_rs_mag, w_rt_mag;
  logic [WIDTH:0]       w_mul_sum, w_rem_sh;
  logic [WIDTH-1:0]     w_diff;
  logic                 w_ge;
  logic [2*WIDTH-1:0]   w_mul_next, w_div_next, w_neg_acc;
  logic [WIDTH-1:0]     w_neg_q, w_neg_r, w_fix_hi, w_fix_lo;

  // Priority mult > multu > div > divu falls out of these two decodes.
  assign w_go     = start & (op_mult | op_multu | op_div | op_divu) & (r_state == IDLE);
  assign w_signed = op_mult | (~op_multu & op_div);
  assign w_is_div = ~op_mult & ~op_multu;
  assign w_rs_neg = w_signed & rs_val[WIDTH-1];
  assign w_rt_neg = w_signed & rt_val[WIDTH-1];
  assign w_rs_mag = w_rs_neg ? -rs_val : rs_val;
  assign w_rt_mag = w_rt_neg ? -rt_val : rt_val;

  // Multiply: multiplier sits in the low half and is consumed LSB first.
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : '0);
  assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

  // Divide: remainder in the high half, dividend shifts out of the low half as quotient shifts in.
  assign w_rem_sh   = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_ge       = w_rem_sh >= {1'b0, r_b};
  assign w_diff     = w_rem_sh[WIDTH-1:0] - r_b;
  assign w_div_next = w_ge ? {w_diff, r_acc[WIDTH-2:0], 1'b1}
                           : {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};

  assign w_neg_acc = -r_acc;
  assign w_neg_q   = -r_acc[WIDTH-1:0];
  assign w_neg_r   = -r_acc[2*WIDTH-1:WIDTH];

  always_comb begin
    w_fix_hi = r_acc[2*WIDTH-1:WIDTH];
    w_fix_lo = r_acc[WIDTH-1:0];
    if (r_dbz) begin
      w_fix_hi = r_rs;
      w_fix_lo = '1;
    end else if (r_is_div) begin
      if (r_neg_q) w_fix_lo = w_neg_q;
      if (r_neg_r) w_fix_hi = w_neg_r;
    end else if (r_neg_q) begin
      {w_fix_hi, w_fix_lo} = w_neg_acc;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_go) w_next = CALC;
      CALC:    if (r_cnt == CNT_W'(WIDTH - 1)) w_next = FIX;
      FIX:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_b      <= '0;
      r_rs     <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dbz    <= 1'b0;
      r_done   <= 1'b0;
      r_dz     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_dz   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_go) begin
            r_cnt    <= '0;
            r_is_div <= w_is_div;
            r_neg_q  <= w_rs_neg ^ w_rt_neg;
            r_neg_r  <= w_rs_neg;
            r_dbz    <= w_is_div & (rt_val == '0);
            r_rs     <= rs_val;
            if (w_is_div) begin
              r_acc <= {{WIDTH{1'b0}}, w_rs_mag};
              r_b   <= w_rt_mag;
            end else begin
              r_acc <= {{WIDTH{1'b0}}, w_rt_mag};
              r_b   <= w_rs_mag;
            end
          end else begin
            if (op_mthi) r_hi <= rs_val;
            if (op_mtlo) r_lo <= rs_val;
          end
        end
        CALC: begin
          r_acc <= r_is_div ? w_div_next : w_mul_next;
          r_cnt <= r_cnt + CNT_W'(1);
        end
        FIX: begin
          r_hi   <= w_fix_hi;
          r_lo   <= w_fix_lo;
          r_done <= 1'b1;
          r_dz   <= r_dbz;
        end
        default: ;
      endcase
    end
  end

  assign hi          = r_hi;
  assign lo          = r_lo;
  assign busy        = (r_state != IDLE);
  assign done        = r_done;
  assign div_by_zero = r_dz;
  assign stall       = busy & (start | op_mfhi | op_mflo | op_mthi | op_mtlo);

endmodule
